rv32i_issue_ctrl: RTL and testbench

//  In-order issue controller between fetch and execute for the RV32I core. Accepts one raw instruction
//  per cycle, holds it in a single-entry issue register and tracks destination registers in a scoreboard.

---
 rtl/rv32i_pkg.sv | 91 +++++++++
 rtl/rv32i_scoreboard.sv | 52 +++++
 rtl/rv32i_issue_ctrl.sv | 162 ++++++++++++++++
 tb/tb_rv32i_issue_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared RV32I issue-stage definitions: major opcode values
//                (instr[6:2]), issue class encoding, issue FSM states and
//                class property helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    // Major opcode field instr[6:2] (instr[1:0] must be 2'b11 for RV32I)
    localparam logic [4:0] c_OPC_LOAD     = 5'b00000;
    localparam logic [4:0] c_OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] c_OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] c_OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] c_OPC_STORE    = 5'b01000;
    localparam logic [4:0] c_OPC_OP       = 5'b01100;
    localparam logic [4:0] c_OPC_LUI      = 5'b01101;
    localparam logic [4:0] c_OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] c_OPC_JALR     = 5'b11001;
    localparam logic [4:0] c_OPC_JAL      = 5'b11011;
    localparam logic [4:0] c_OPC_SYSTEM   = 5'b11100;

    // Opcode class presented to execute alongside the instruction word
    typedef enum logic [3:0] {
        CLS_NONE     = 4'd0,
        CLS_LOAD     = 4'd1,
        CLS_STORE    = 4'd2,
        CLS_MEMORDER = 4'd3,
        CLS_ALUREG   = 4'd4,
        CLS_ALUIMM   = 4'd5,
        CLS_LUI      = 4'd6,
        CLS_AUIPC    = 4'd7,
        CLS_JAL      = 4'd8,
        CLS_JALR     = 4'd9,
        CLS_BRANCH   = 4'd10,
        CLS_SYSCALL  = 4'd11,
        CLS_ILLEGAL  = 4'd12
    } issueClass_t;

    // Issue register state
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HELD  = 2'd1,
        ST_DRAIN = 2'd2
    } issueState_t;

    // Map the 7-bit opcode to its issue class; anything unrecognised is ILLEGAL
    function automatic issueClass_t decodeClass(input logic [6:0] opcode);
        issueClass_t cls;
        cls = CLS_ILLEGAL;
        if (opcode[1:0] == 2'b11) begin
            case (opcode[6:2])
                c_OPC_LOAD:     cls = CLS_LOAD;
                c_OPC_MISC_MEM: cls = CLS_MEMORDER;
                c_OPC_OP_IMM:   cls = CLS_ALUIMM;
                c_OPC_AUIPC:    cls = CLS_AUIPC;
                c_OPC_STORE:    cls = CLS_STORE;
                c_OPC_OP:       cls = CLS_ALUREG;
                c_OPC_LUI:      cls = CLS_LUI;
                c_OPC_BRANCH:   cls = CLS_BRANCH;
                c_OPC_JALR:     cls = CLS_JALR;
                c_OPC_JAL:      cls = CLS_JAL;
                c_OPC_SYSTEM:   cls = CLS_SYSCALL;
                default:        cls = CLS_ILLEGAL;
            endcase
        end
        return cls;
    endfunction

    function automatic logic usesRs1(input issueClass_t cls);
        return cls inside {CLS_LOAD, CLS_STORE, CLS_ALUREG, CLS_ALUIMM,
                           CLS_JALR, CLS_BRANCH, CLS_SYSCALL};
    endfunction

    function automatic logic usesRs2(input issueClass_t cls);
        return cls inside {CLS_STORE, CLS_BRANCH, CLS_ALUREG};
    endfunction

    function automatic logic writesRd(input issueClass_t cls);
        return cls inside {CLS_LOAD, CLS_ALUREG, CLS_ALUIMM, CLS_LUI,
                           CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_SYSCALL};
    endfunction

    // Ordering instructions wait until every outstanding producer has retired
    function automatic logic needsDrain(input issueClass_t cls);
        return cls inside {CLS_MEMORDER, CLS_SYSCALL};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_scoreboard
//  Description : Destination-register busy vector. A set (issue) and a clear
//                (writeback) may hit the same register in one cycle; the set
//                wins because it belongs to the newer producer. x0 is never
//                marked busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_scoreboard #(
    parameter int REG_COUNT = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      setEn,
    input  logic [REG_COUNT-1:0]      setIdx,
    input  logic                      clrEn,
    input  logic [REG_COUNT-1:0]      clrIdx,
    output logic [(2**REG_COUNT)-1:0] busy
);

    localparam int c_NREGS = 2**REG_COUNT;

    logic [c_NREGS-1:0] r_busy;
    logic [c_NREGS-1:0] w_setMask;
    logic [c_NREGS-1:0] w_clrMask;

    // One-hot set/clear masks with register 0 excluded
    always_comb begin
        w_setMask = '0;
        w_clrMask = '0;
        if (setEn && (setIdx != '0)) begin
            w_setMask[setIdx] = 1'b1;
        end
        if (clrEn && (clrIdx != '0)) begin
            w_clrMask[clrIdx] = 1'b1;
        end
    end

    // Apply clear first, then set, so a same-cycle set survives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clrMask) | w_setMask;
        end
    end

    assign busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/rv32i_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_issue_ctrl
//  Description : In-order single-entry issue stage for the RV32I core. Holds
//                one instruction, checks RAW/WAW hazards against the register
//                scoreboard and drains outstanding producers ahead of
//                FENCE/SYSTEM before releasing to execute.
//  Options     : RV32I_ISSUE_WB_BYPASS_EN - hazard/drain checks ignore the
//                register retiring in the current cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_issue_ctrl
    import rv32i_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [XLEN-1:0]           instrIn,
    input  logic                      instrValid,
    output logic                      instrReady,
    input  logic                      flush,
    output logic                      issueValid,
    input  logic                      issueReady,
    output logic [XLEN-1:0]           issueInstr,
    output logic [3:0]                issueClass,
    input  logic                      wbValid,
    input  logic [REG_COUNT-1:0]      wbRd,
    output logic [(2**REG_COUNT)-1:0] sbBusy
);

    localparam int c_NREGS = 2**REG_COUNT;

    issueState_t           r_state;
    issueState_t           w_stateNext;
    logic [XLEN-1:0]       r_instr;
    issueClass_t           r_class;

    logic [REG_COUNT-1:0]  w_rs1;
    logic [REG_COUNT-1:0]  w_rs2;
    logic [REG_COUNT-1:0]  w_rd;
    logic [c_NREGS-1:0]    w_busyEff;
    logic                  w_drainNeeded;
    logic                  w_hazard;
    logic                  w_issueValid;
    logic                  w_fire;
    logic                  w_instrReady;
    logic                  w_accept;
    logic                  w_sbSet;

    assign w_rs1 = r_instr[15 +: REG_COUNT];
    assign w_rs2 = r_instr[20 +: REG_COUNT];
    assign w_rd  = r_instr[7  +: REG_COUNT];

`ifdef RV32I_ISSUE_WB_BYPASS_EN
    logic [c_NREGS-1:0] w_clrMask;

    // Register retiring this cycle no longer blocks its consumers
    always_comb begin
        w_clrMask = '0;
        if (wbValid && (wbRd != '0)) begin
            w_clrMask[wbRd] = 1'b1;
        end
    end

    assign w_busyEff = sbBusy & ~w_clrMask;
`else
    assign w_busyEff = sbBusy;
`endif

    // Ordering instructions stall while anything is outstanding; others
    // stall on a busy source they read or a busy destination they write.
    assign w_drainNeeded = needsDrain(r_class) && (|w_busyEff);
    assign w_hazard      = (usesRs1(r_class)  && w_busyEff[w_rs1]) ||
                           (usesRs2(r_class)  && w_busyEff[w_rs2]) ||
                           (writesRd(r_class) && w_busyEff[w_rd])  ||
                           w_drainNeeded;

    assign w_issueValid = (r_state == ST_HELD) && !w_hazard && !flush;
    assign w_fire       = w_issueValid && issueReady;
    assign w_instrReady = !rst && !flush &&
                          ((r_state == ST_EMPTY) || ((r_state == ST_HELD) && w_fire));
    assign w_accept     = instrValid && w_instrReady;
    assign w_sbSet      = w_fire && writesRd(r_class);

    // Issue FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state: flush beats fire and accept; fire with a new accept stays HELD
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_stateNext = ST_HELD;
                end
            end
            ST_HELD: begin
                if (flush) begin
                    w_stateNext = ST_EMPTY;
                end else if (w_fire) begin
                    w_stateNext = w_accept ? ST_HELD : ST_EMPTY;
                end else if (w_drainNeeded) begin
                    w_stateNext = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    w_stateNext = ST_EMPTY;
                end else if (w_busyEff == '0) begin
                    w_stateNext = ST_HELD;
                end
            end
            default: begin
                w_stateNext = ST_EMPTY;
            end
        endcase
    end

    // Issue register: load on accept, clear when dropped or consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr <= '0;
            r_class <= CLS_NONE;
        end else if (flush) begin
            r_instr <= '0;
            r_class <= CLS_NONE;
        end else if (w_accept) begin
            r_instr <= instrIn;
            r_class <= decodeClass(instrIn[6:0]);
        end else if (w_fire) begin
            r_instr <= '0;
            r_class <= CLS_NONE;
        end
    end

    rv32i_scoreboard #(
        .REG_COUNT (REG_COUNT)
    ) u_scoreboard (
        .clk    (clk),
        .rst    (rst),
        .setEn  (w_sbSet),
        .setIdx (w_rd),
        .clrEn  (wbValid),
        .clrIdx (wbRd),
        .busy   (sbBusy)
    );

    assign instrReady = w_instrReady;
    assign issueValid = w_issueValid;
    assign issueInstr = r_instr;
    assign issueClass = r_class;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_issue_ctrl
//  Description : Self-checking bench for rv32i_issue_ctrl. Offered
//                instructions are queued as expected issues; a negedge monitor
//                pops and compares every issued word and class.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_issue_ctrl;
    import rv32i_pkg::*;

`ifdef RV32I_ISSUE_WB_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    localparam logic [31:0] c_ADDI_X1 = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] c_ADDI_X2 = 32'h0060_0113; // addi x2,x0,6
    localparam logic [31:0] c_ADDI_X5 = 32'h0010_0293; // addi x5,x0,1
    localparam logic [31:0] c_LW_X1   = 32'h0000_2083; // lw   x1,0(x0)
    localparam logic [31:0] c_ADD_X3  = 32'h0020_81B3; // add  x3,x1,x2
    localparam logic [31:0] c_FENCE   = 32'h0000_000F;
    localparam logic [31:0] c_BADOP   = 32'h0000_007F;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instrIn;
    logic        instrValid;
    logic        instrReady;
    logic        flush;
    logic        issueValid;
    logic        issueReady;
    logic [31:0] issueInstr;
    logic [3:0]  issueClass;
    logic        wbValid;
    logic [4:0]  wbRd;
    logic [31:0] sbBusy;

    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  cls;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rv32i_issue_ctrl #(
        .XLEN      (32),
        .REG_COUNT (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instrIn    (instrIn),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .flush      (flush),
        .issueValid (issueValid),
        .issueReady (issueReady),
        .issueInstr (issueInstr),
        .issueClass (issueClass),
        .wbValid    (wbValid),
        .wbRd       (wbRd),
        .sbBusy     (sbBusy)
    );

    // Scoreboard monitor: every handshake must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && issueValid && issueReady) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: issued %h class %0d, nothing expected", issueInstr, issueClass);
            end else begin
                monExp = expQ.pop_front();
                if (issueInstr !== monExp.instr || issueClass !== monExp.cls) begin
                    errors++;
                    $display("FAIL issue_payload: got %h class %0d, expected %h class %0d",
                             issueInstr, issueClass, monExp.instr, monExp.cls);
                end
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instrValid = 1'b0;
        instrIn    = '0;
        flush      = 1'b0;
        wbValid    = 1'b0;
        wbRd       = '0;
    endtask

    task automatic offer(input logic [31:0] ins, input issueClass_t cls);
        instrValid = 1'b1;
        instrIn    = ins;
        expQ.push_back('{instr: ins, cls: cls});
    endtask

    task automatic doReset();
        cyc();
        idle();
        rst        = 1'b1;
        issueReady = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        instrValid = 1'b1;
        instrIn    = c_ADDI_X1;
        @(negedge clk);
        checks++; if (instrReady !== 1'b0) begin errors++; $display("FAIL rst_instrReady: got %b, expected 0", instrReady); end
        checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL rst_issueValid: got %b, expected 0", issueValid); end
        checks++; if (issueInstr !== 32'h0) begin errors++; $display("FAIL rst_issueInstr: got %h, expected 0", issueInstr); end
        checks++; if (issueClass !== CLS_NONE) begin errors++; $display("FAIL rst_issueClass: got %0d, expected %0d", issueClass, CLS_NONE); end
        checks++; if (sbBusy !== 32'h0) begin errors++; $display("FAIL rst_sbBusy: got %h, expected 0", sbBusy); end
        cyc();
        rst = 1'b0;
        idle();
        @(negedge clk);
        checks++; if (instrReady !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b, expected 1", instrReady); end
    endtask

    task automatic test_back_to_back();
        doReset();
        cyc(); offer(c_ADDI_X1, CLS_ALUIMM);
        @(negedge clk);
        checks++; if (instrReady !== 1'b1) begin errors++; $display("FAIL b2b_accept1: got %b, expected 1", instrReady); end
        cyc(); offer(c_ADDI_X2, CLS_ALUIMM);
        @(negedge clk);
        checks++; if (issueValid !== 1'b1 || instrReady !== 1'b1) begin errors++; $display("FAIL b2b_fire_accept: valid %b ready %b, expected 1 1", issueValid, instrReady); end
        cyc(); idle();
        @(negedge clk);
        checks++; if (issueValid !== 1'b1) begin errors++; $display("FAIL b2b_issue2: got %b, expected 1", issueValid); end
        checks++; if (sbBusy !== 32'h2) begin errors++; $display("FAIL b2b_busy_mid: got %h, expected 2", sbBusy); end
        cyc();
        @(negedge clk);
        checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b, expected 0", issueValid); end
        checks++; if (sbBusy !== 32'h6) begin errors++; $display("FAIL b2b_busy: got %h, expected 6", sbBusy); end
    endtask

    task automatic test_raw_hazard();
        doReset();
        cyc(); offer(c_LW_X1, CLS_LOAD);
        cyc(); offer(c_ADD_X3, CLS_ALUREG);
        @(negedge clk);
        checks++; if (issueValid !== 1'b1) begin errors++; $display("FAIL raw_lw_issue: got %b, expected 1", issueValid); end
        cyc(); idle();
        @(negedge clk);
        checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL raw_stall1: got %b, expected 0", issueValid); end
        checks++; if (sbBusy !== 32'h2) begin errors++; $display("FAIL raw_busy: got %h, expected 2", sbBusy); end
        cyc();
        @(negedge clk);
        checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL raw_stall2: got %b, expected 0", issueValid); end
        cyc(); wbValid = 1'b1; wbRd = 5'd1;
        @(negedge clk);
        checks++; if (issueValid !== c_BYPASS) begin errors++; $display("FAIL raw_wb_cycle: got %b, expected %b", issueValid, c_BYPASS); end
        cyc(); idle();
        @(negedge clk);
        checks++; if (issueValid !== !c_BYPASS) begin errors++; $display("FAIL raw_after_wb: got %b, expected %b", issueValid, !c_BYPASS); end
        cyc();
        @(negedge clk);
        checks++; if (sbBusy !== 32'h8) begin errors++; $display("FAIL raw_busy_x3: got %h, expected 8", sbBusy); end
    endtask

    task automatic test_fence_drain();
        doReset();
        cyc(); offer(c_ADDI_X1, CLS_ALUIMM);
        cyc(); offer(c_FENCE, CLS_MEMORDER);
        cyc(); idle();
        @(negedge clk);
        checks++; if (issueValid !== 1'b0 || instrReady !== 1'b0) begin errors++; $display("FAIL fence_held: valid %b ready %b, expected 0 0", issueValid, instrReady); end
        checks++; if (sbBusy !== 32'h2) begin errors++; $display("FAIL fence_busy: got %h, expected 2", sbBusy); end
        cyc();
        @(negedge clk);
        checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL fence_drain: got %b, expected 0", issueValid); end
        cyc(); wbValid = 1'b1; wbRd = 5'd1;
        @(negedge clk);
        checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL fence_wb_cycle: got %b, expected 0", issueValid); end
        cyc(); idle();
        @(negedge clk);
        checks++; if (issueValid !== c_BYPASS) begin errors++; $display("FAIL fence_wb_plus1: got %b, expected %b", issueValid, c_BYPASS); end
        cyc();
        @(negedge clk);
        checks++; if (issueValid !== !c_BYPASS) begin errors++; $display("FAIL fence_wb_plus2: got %b, expected %b", issueValid, !c_BYPASS); end
        cyc();
        @(negedge clk);
        checks++; if (sbBusy !== 32'h0 || instrReady !== 1'b1) begin errors++; $display("FAIL fence_done: busy %h ready %b, expected 0 1", sbBusy, instrReady); end
    endtask

    task automatic test_stall_flush();
        doReset();
        issueReady = 1'b0;
        cyc(); offer(c_ADDI_X5, CLS_ALUIMM);
        cyc(); idle();
        @(negedge clk);
        checks++; if (issueValid !== 1'b1 || issueInstr !== c_ADDI_X5) begin errors++; $display("FAIL flush_hold: valid %b instr %h, expected 1 %h", issueValid, issueInstr, c_ADDI_X5); end
        cyc();
        flush      = 1'b1;
        instrValid = 1'b1;
        instrIn    = c_ADDI_X2;
        @(negedge clk);
        checks++; if (issueValid !== 1'b0 || instrReady !== 1'b0) begin errors++; $display("FAIL flush_cycle: valid %b ready %b, expected 0 0", issueValid, instrReady); end
        checks++; if (issueInstr !== c_ADDI_X5) begin errors++; $display("FAIL flush_stable: got %h, expected %h", issueInstr, c_ADDI_X5); end
        void'(expQ.pop_back());
        cyc(); idle();
        @(negedge clk);
        checks++; if (issueValid !== 1'b0 || instrReady !== 1'b1) begin errors++; $display("FAIL flush_empty: valid %b ready %b, expected 0 1", issueValid, instrReady); end
        checks++; if (issueInstr !== 32'h0 || issueClass !== CLS_NONE) begin errors++; $display("FAIL flush_payload: instr %h class %0d, expected 0 0", issueInstr, issueClass); end
        checks++; if (sbBusy !== 32'h0) begin errors++; $display("FAIL flush_busy: got %h, expected 0", sbBusy); end
        issueReady = 1'b1;
    endtask

    task automatic test_set_wins();
        doReset();
        cyc(); offer(c_ADDI_X5, CLS_ALUIMM);
        cyc(); idle(); wbValid = 1'b1; wbRd = 5'd5;
        @(negedge clk);
        checks++; if (issueValid !== 1'b1) begin errors++; $display("FAIL setwin_issue: got %b, expected 1", issueValid); end
        cyc(); idle(); wbValid = 1'b1; wbRd = 5'd0;
        @(negedge clk);
        checks++; if (sbBusy !== 32'h20) begin errors++; $display("FAIL setwin_busy: got %h, expected 20", sbBusy); end
        cyc(); wbValid = 1'b1; wbRd = 5'd5;
        @(negedge clk);
        checks++; if (sbBusy !== 32'h20) begin errors++; $display("FAIL wb_x0_ignored: got %h, expected 20", sbBusy); end
        cyc(); idle();
        @(negedge clk);
        checks++; if (sbBusy !== 32'h0) begin errors++; $display("FAIL wb_clear: got %h, expected 0", sbBusy); end
    endtask

    task automatic test_illegal_and_reset();
        doReset();
        cyc(); offer(c_ADDI_X1, CLS_ALUIMM);
        cyc(); offer(c_BADOP, CLS_ILLEGAL);
        cyc(); idle();
        @(negedge clk);
        checks++; if (issueValid !== 1'b1 || issueClass !== CLS_ILLEGAL) begin errors++; $display("FAIL illegal_issue: valid %b class %0d, expected 1 %0d", issueValid, issueClass, CLS_ILLEGAL); end
        cyc(); offer(c_ADD_X3, CLS_ALUREG);
        @(negedge clk);
        checks++; if (sbBusy !== 32'h2 || instrReady !== 1'b1) begin errors++; $display("FAIL illegal_no_sb: busy %h ready %b, expected 2 1", sbBusy, instrReady); end
        cyc(); idle();
        @(negedge clk);
        checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b, expected 0", issueValid); end
        cyc(); rst = 1'b1;
        @(negedge clk);
        checks++; if (issueValid !== 1'b0 || instrReady !== 1'b0) begin errors++; $display("FAIL midrst_hs: valid %b ready %b, expected 0 0", issueValid, instrReady); end
        checks++; if (sbBusy !== 32'h0 || issueInstr !== 32'h0 || issueClass !== CLS_NONE) begin errors++; $display("FAIL midrst_state: busy %h instr %h class %0d, expected 0 0 0", sbBusy, issueInstr, issueClass); end
        void'(expQ.pop_back());
        cyc(); rst = 1'b0;
        @(negedge clk);
        checks++; if (instrReady !== 1'b1 || issueValid !== 1'b0) begin errors++; $display("FAIL midrst_release: ready %b valid %b, expected 1 0", instrReady, issueValid); end
    endtask

    initial begin
        rst        = 1'b1;
        issueReady = 1'b1;
        idle();
        test_reset();
        test_back_to_back();
        test_raw_hazard();
        test_fence_drain();
        test_stall_flush();
        test_set_wins();
        test_illegal_and_reset();
        cyc();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: %0d entries left, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
